// File: rtl/mux_project_ctrl.sv
// mux_project_ctrl
//   Selects one of NUM_PROJ wrapped user projects on the shared tile-mux
//   fabric. It drives that project's enable, broadcasts the packed input word
//   to every wrapper, and returns the selected wrapper's output word. Each
//   change of selection runs a reset handover: the old project is quiesced in
//   reset, then the new project is enabled and held in reset.
//
// Ports
//   clk, rst_n   controller clock / asynchronous active-low reset
//   sel_addr     project address, sampled only together with sel_load
//   sel_load     single-cycle switch request (ignored while sel_busy)
//   sel_busy     handover in progress (QUIESCE or SWITCH)
//   sel_active   selected project running (ACTIVE)
//   sel_err      sticky: an out-of-range address was loaded
//   cur_addr     address of the currently enabled project
//   user_rst_n   pad reset, forwarded to the project only while ACTIVE
//   ui_in/uio_in pad inputs, broadcast in iw_o
//   ena_o        one-hot (or zero) enable per wrapper
//   iw_o         {uio_in, ui_in, proj_rst_n, clk}
//   ow_i         all wrapper outputs, project k in [24k+23:24k]
//   ow_o         selected {uio_oe, uio_out, uo_out}, masked by state
module mux_project_ctrl #(
  parameter int NUM_PROJ       = 16,
  parameter int ADDR_W         = 4,
  parameter int RST_CYCLES     = 8,
  parameter int QUIESCE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      sel_addr,
  input  logic                   sel_load,
  output logic                   sel_busy,
  output logic                   sel_active,
  output logic                   sel_err,
  output logic [ADDR_W-1:0]      cur_addr,
  input  logic                   user_rst_n,
  input  logic [7:0]             ui_in,
  input  logic [7:0]             uio_in,
  output logic [NUM_PROJ-1:0]    ena_o,
  output logic [17:0]            iw_o,
  input  logic [NUM_PROJ*24-1:0] ow_i,
  output logic [23:0]            ow_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUIESCE = 2'd1,
    S_SWITCH  = 2'd2,
    S_ACTIVE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pending_q, pending_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [NUM_PROJ-1:0] ena_q, ena_d;
  logic                err_q, err_d;
  // Set when the pending request was out of range: QUIESCE then ends in IDLE.
  logic                drop_q, drop_d;
  logic                proj_rst_n_q, proj_rst_n_d;
  logic                addr_ok;

  assign addr_ok = int'(sel_addr) < NUM_PROJ;

  function automatic logic [NUM_PROJ-1:0] one_hot(input logic [ADDR_W-1:0] a);
    logic [NUM_PROJ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PROJ; i++) v[i] = (a == ADDR_W'(i));
    return v;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    cur_addr_d = cur_addr_q;
    ena_d      = ena_q;
    err_d      = err_q;
    drop_d     = drop_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_load) begin
          if (addr_ok) begin
            // Nothing is enabled, so there is no old project to quiesce.
            pending_d  = sel_addr;
            cur_addr_d = sel_addr;
            ena_d      = one_hot(sel_addr);
            cnt_d      = 8'(RST_CYCLES);
            err_d      = 1'b0;
            state_d    = S_SWITCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (sel_load) begin
          cnt_d   = 8'(QUIESCE_CYCLES);
          state_d = S_QUIESCE;
          if (addr_ok) begin
            pending_d = sel_addr;
            drop_d    = 1'b0;
            err_d     = 1'b0;
          end else begin
            drop_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_QUIESCE: begin
        // Counter is loaded with N on entry and the state is left on the edge
        // where it steps 1 -> 0, giving exactly N cycles in the state.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          if (drop_q) begin
            ena_d   = '0;
            cnt_d   = 8'd0;
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cur_addr_d = pending_q;
            ena_d      = one_hot(pending_q);
            cnt_d      = 8'(RST_CYCLES);
            state_d    = S_SWITCH;
          end
        end
      end
      S_SWITCH: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_ACTIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Derived from the next state so the project reset is released on the
    // first ACTIVE cycle and asserted on the first handover cycle; ena_d only
    // ever changes on edges where this is 0.
    proj_rst_n_d = (state_d == S_ACTIVE) && user_rst_n;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      pending_q    <= '0;
      cur_addr_q   <= '0;
      ena_q        <= '0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
      proj_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      cur_addr_q   <= cur_addr_d;
      ena_q        <= ena_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      proj_rst_n_q <= proj_rst_n_d;
    end
  end

  assign sel_busy   = (state_q == S_QUIESCE) || (state_q == S_SWITCH);
  assign sel_active = (state_q == S_ACTIVE);
  assign sel_err    = err_q;
  assign cur_addr   = cur_addr_q;
  assign ena_o      = ena_q;
  assign iw_o       = {uio_in, ui_in, proj_rst_n_q, clk};

  // cur_addr_q only ever holds a validated address, so the slice is in range.
  logic [23:0] ow_sel;
  assign ow_sel = ow_i[24*int'(cur_addr_q) +: 24];

  always_comb begin
    ow_o = 24'h0;
    unique case (state_q)
      S_ACTIVE:            ow_o = ow_sel;
      // uio_oe forced low so the pads stay inputs during a handover.
      S_QUIESCE, S_SWITCH: ow_o = {8'h00, ow_sel[15:0]};
      default:             ow_o = 24'h0;
    endcase
  end

endmodule

// File: tb/tb_mux_project_ctrl.sv
// Directed bench for mux_project_ctrl with NUM_PROJ=12 so that addresses
// 12..15 are out of range. Expected values are pushed to a scoreboard queue
// as stimulus is applied and popped when the DUT output is sampled.
module tb_mux_project_ctrl;
  localparam int NP = 12;
  localparam int AW = 4;
  localparam int RC = 8;
  localparam int QC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] sel_addr = '0;
  logic          sel_load = 1'b0;
  logic          sel_busy, sel_active, sel_err;
  logic [AW-1:0] cur_addr;
  logic          user_rst_n = 1'b1;
  logic [7:0]    ui_in = 8'h5A;
  logic [7:0]    uio_in = 8'hC3;
  logic [NP-1:0] ena_o;
  logic [17:0]   iw_o;
  logic [NP*24-1:0] ow_i;
  logic [23:0]   ow_o;

  mux_project_ctrl #(.NUM_PROJ(NP), .ADDR_W(AW), .RST_CYCLES(RC), .QUIESCE_CYCLES(QC)) dut (
    .clk(clk), .rst_n(rst_n), .sel_addr(sel_addr), .sel_load(sel_load),
    .sel_busy(sel_busy), .sel_active(sel_active), .sel_err(sel_err),
    .cur_addr(cur_addr), .user_rst_n(user_rst_n), .ui_in(ui_in), .uio_in(uio_in),
    .ena_o(ena_o), .iw_o(iw_o), .ow_i(ow_i), .ow_o(ow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [23:0] ow_of(input int k);
    return {8'(8'hC0 + k), 8'(8'h10 + k), 8'(8'h50 + k)};
  endfunction

  function automatic logic [NP-1:0] oh(input int k);
    logic [NP-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    it = sb_q.pop_front();
    n_checks++;
    assert (obs === it.exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
  endtask

  // Push and compare in one step for directly sampled values.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    check(obs);
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse sel_load so that the next rising edge is E0; returns at E0+1.
  task automatic load(input logic [AW-1:0] a);
    sel_addr = a;
    sel_load = 1'b1;
    tick(1);
    sel_load = 1'b0;
  endtask

  // Cycles from E0+1 until sel_active rises, bounded.
  task automatic wait_active(input int limit, output int cyc);
    cyc = 1;
    while (!sel_active && cyc < limit) begin
      tick(1);
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    for (int k = 0; k < NP; k++) ow_i[24*k +: 24] = ow_of(k);

    // Power-up reset.
    tick(3);
    chk("rst_ena", 32'(ena_o), 0);
    chk("rst_busy", 32'(sel_busy), 0);
    chk("rst_active", 32'(sel_active), 0);
    chk("rst_err", 32'(sel_err), 0);
    chk("rst_cur", 32'(cur_addr), 0);
    chk("rst_ow", 32'(ow_o), 0);
    chk("rst_prst", 32'(iw_o[1]), 0);
    chk("rst_iw_pads", 32'(iw_o[17:2]), 32'h0000C35A);
    rst_n = 1'b1;
    tick(2);

    // Load 3 from IDLE.
    load(4'd3);
    chk("p_ena", 32'(ena_o), 32'(oh(3)));
    chk("p_cur", 32'(cur_addr), 3);
    chk("p_busy", 32'(sel_busy), 1);
    chk("p_ow_switch", 32'(ow_o), 32'({8'h00, ow_of(3)[15:0]}));
    tick(RC - 1);
    chk("p_active_e8", 32'(sel_active), 0);
    tick(1);
    chk("p_active_e9", 32'(sel_active), 1);
    chk("p_busy_e9", 32'(sel_busy), 0);
    chk("p_prst_e9", 32'(iw_o[1]), 1);
    chk("p_ow_active", 32'(ow_o), 32'(ow_of(3)));
    user_rst_n = 1'b0;
    chk("p_prst_lag", 32'(iw_o[1]), 1);
    tick(1);
    chk("p_prst_follow0", 32'(iw_o[1]), 0);
    user_rst_n = 1'b1;
    tick(1);
    chk("p_prst_follow1", 32'(iw_o[1]), 1);

    // Switch 3 -> 5.
    load(4'd5);
    for (int i = 1; i <= QC; i++) begin
      chk("s_ena_old", 32'(ena_o), 32'(oh(3)));
      chk("s_prst_q", 32'(iw_o[1]), 0);
      chk("s_cur_old", 32'(cur_addr), 3);
      chk("s_oe_q", 32'(ow_o[23:16]), 0);
      tick(1);
    end
    for (int i = 1; i <= RC; i++) begin
      chk("s_ena_new", 32'(ena_o), 32'(oh(5)));
      chk("s_oe_s", 32'(ow_o[23:16]), 0);
      chk("s_busy", 32'(sel_busy), 1);
      tick(1);
    end
    chk("s_active_e11", 32'(sel_active), 1);
    chk("s_cur_new", 32'(cur_addr), 5);
    chk("s_ow", 32'(ow_o), 32'(ow_of(5)));

    // Same-address reload of 5.
    load(4'd5);
    for (int i = 1; i <= QC + RC; i++) begin
      chk("r_prst_low", 32'(iw_o[1]), 0);
      chk("r_ena_hold", 32'(ena_o), 32'(oh(5)));
      tick(1);
    end
    chk("r_prst_high", 32'(iw_o[1]), 1);
    chk("r_active", 32'(sel_active), 1);

    // Loads while busy are ignored (valid and invalid).
    load(4'd2);
    tick(QC + 1);
    load(4'd7);
    load(4'd15);
    wait_active(40, cyc);
    chk("b_latency", 32'(cyc + QC + 3), QC + RC + 1);
    chk("b_cur", 32'(cur_addr), 2);
    chk("b_ena", 32'(ena_o), 32'(oh(2)));
    chk("b_err", 32'(sel_err), 0);

    // Invalid address from ACTIVE: QUIESCE then IDLE.
    load(4'd15);
    chk("i_err", 32'(sel_err), 1);
    chk("i_busy", 32'(sel_busy), 1);
    chk("i_ena_q", 32'(ena_o), 32'(oh(2)));
    tick(QC);
    chk("i_ena_idle", 32'(ena_o), 0);
    chk("i_ow_idle", 32'(ow_o), 0);
    chk("i_cur", 32'(cur_addr), 2);
    chk("i_state", 32'({sel_busy, sel_active}), 0);
    chk("i_err_sticky", 32'(sel_err), 1);
    // Invalid from IDLE stays IDLE.
    load(4'd12);
    chk("i2_err", 32'(sel_err), 1);
    chk("i2_busy", 32'(sel_busy), 0);
    chk("i2_ena", 32'(ena_o), 0);
    // Valid load clears the error.
    load(4'd11);
    chk("i3_err_clr", 32'(sel_err), 0);
    chk("i3_ena", 32'(ena_o), 32'(oh(11)));
    wait_active(40, cyc);
    chk("i3_latency", 32'(cyc), RC + 1);

    // Reset during QUIESCE.
    load(4'd6);
    chk("x_busy_pre", 32'(sel_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("x_ena", 32'(ena_o), 0);
    chk("x_busy", 32'(sel_busy), 0);
    chk("x_active", 32'(sel_active), 0);
    chk("x_cur", 32'(cur_addr), 0);
    chk("x_ow", 32'(ow_o), 0);
    chk("x_prst", 32'(iw_o[1]), 0);
    tick(2);
    chk("x_ena_held", 32'(ena_o), 0);
    rst_n = 1'b1;
    tick(1);
    load(4'd4);
    chk("x2_ena", 32'(ena_o), 32'(oh(4)));
    wait_active(40, cyc);
    chk("x2_latency", 32'(cyc), RC + 1);
    chk("x2_ow", 32'(ow_o), 32'(ow_of(4)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time bound in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
